// File: rtl/async_fifo_pkg.sv
// Shared helpers for the async FIFO pointer controllers: gray/binary pointer conversion.
// Functions work on a wide word; callers extend their pointer in and truncate the result.
package async_fifo_pkg;

    localparam int PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    function automatic ptr_word_t bin2gray(input ptr_word_t bin);
        return (bin >> 1) ^ bin;
    endfunction

    // Zero-extended gray input decodes correctly because the upper zeros contribute nothing.
    function automatic ptr_word_t gray2bin(input ptr_word_t gray);
        ptr_word_t bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/async_fifo_sync.sv
// Multi-flop synchronizer for a gray-coded pointer crossing into this clock domain.
// Reusable by both the write-side and read-side pointer controllers.
module async_fifo_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_d[gi] = d_i;
            end else begin : g_tail
                assign stage_d[gi] = stage_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= srst_i ? '0 : stage_d[i];
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/async_fifo_wptr_full_ctrl.sv
// Write-side pointer/flag controller of an async FIFO: gray write pointer, full,
// almost-full, fill level and sticky overflow, all in the write clock domain.
module async_fifo_wptr_full_ctrl
    import async_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH         = 4,
    parameter int ALMOST_FULL_BUFFER = 2,
    parameter int SYNC_STAGES        = 2
) (
    input  logic                  wclk_i,
    input  logic                  wreset_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH:0]   rd_ptr_i,
    output logic [ADDR_WIDTH:0]   wr_ptr_o,
    output logic [ADDR_WIDTH-1:0] waddr_o,
    output logic                  wfull_o,
    output logic                  walmost_full_o,
    output logic [ADDR_WIDTH:0]   wlevel_o,
    output logic                  woverflow_o,
    input  logic                  wclr_ovf_i
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [PTR_W-1:0] AF_THRESH = PTR_W'(DEPTH - ALMOST_FULL_BUFFER);

    logic [PTR_W-1:0]      rsync_rd_ptr;
    logic [PTR_W-1:0]      rsync_bin;
    logic                  do_write;
    logic [PTR_W-1:0]      next_bin;
    logic [PTR_W-1:0]      next_gray;

    logic [PTR_W-1:0]      wr_bin_q, wr_bin_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic                  wfull_q, wfull_d;
    logic                  walmost_full_q, walmost_full_d;
    logic [PTR_W-1:0]      wlevel_q, wlevel_d;
    logic                  woverflow_q, woverflow_d;

    async_fifo_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk_i  (wclk_i),
        .srst_i (wreset_i),
        .d_i    (rd_ptr_i),
        .q_o    (rsync_rd_ptr)
    );

    always_comb begin
        do_write  = wr_en_i & ~wfull_q;
        next_bin  = wr_bin_q + PTR_W'(do_write);
        next_gray = PTR_W'(bin2gray(ptr_word_t'(next_bin)));
        rsync_bin = PTR_W'(gray2bin(ptr_word_t'(rsync_rd_ptr)));

        wr_bin_d = next_bin;
        wr_ptr_d = next_gray;
        waddr_d  = next_bin[ADDR_WIDTH-1:0];
        wlevel_d = next_bin - rsync_bin;

        // Full when the write pointer is exactly one lap ahead of the synchronized read pointer.
        wfull_d = (next_gray == {~rsync_rd_ptr[ADDR_WIDTH:ADDR_WIDTH-1],
                                  rsync_rd_ptr[ADDR_WIDTH-2:0]});
        walmost_full_d = (wlevel_d >= AF_THRESH);

        woverflow_d = woverflow_q;
        if (wclr_ovf_i) begin
            woverflow_d = 1'b0;
        end
        if (wr_en_i & wfull_q) begin
            woverflow_d = 1'b1;
        end
    end

    always_ff @(posedge wclk_i) begin
        if (wreset_i) begin
            wr_bin_q       <= '0;
            wr_ptr_q       <= '0;
            waddr_q        <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            wlevel_q       <= '0;
            woverflow_q    <= 1'b0;
        end else begin
            wr_bin_q       <= wr_bin_d;
            wr_ptr_q       <= wr_ptr_d;
            waddr_q        <= waddr_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            wlevel_q       <= wlevel_d;
            woverflow_q    <= woverflow_d;
        end
    end

    assign wr_ptr_o       = wr_ptr_q;
    assign waddr_o        = waddr_q;
    assign wfull_o        = wfull_q;
    assign walmost_full_o = walmost_full_q;
    assign wlevel_o       = wlevel_q;
    assign woverflow_o    = woverflow_q;

endmodule

// File: tb/tb_async_fifo_wptr_full_ctrl.sv
// Bench for the write-side FIFO controller: count-based model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_async_fifo_wptr_full_ctrl;

    localparam int AW      = 4;
    localparam int PW      = AW + 1;
    localparam int AFB     = 2;
    localparam int SS      = 2;
    localparam int DEPTH   = 16;
    localparam int PTR_MOD = 32;

    logic          wclk_i     = 1'b0;
    logic          wreset_i   = 1'b1;
    logic          wr_en_i    = 1'b0;
    logic          wclr_ovf_i = 1'b0;
    logic [AW:0]   rd_ptr_i   = '0;
    logic [AW:0]   wr_ptr_o;
    logic [AW-1:0] waddr_o;
    logic          wfull_o;
    logic          walmost_full_o;
    logic [AW:0]   wlevel_o;
    logic          woverflow_o;

    int total = 0;
    int bad   = 0;

    async_fifo_wptr_full_ctrl #(
        .ADDR_WIDTH         (AW),
        .ALMOST_FULL_BUFFER (AFB),
        .SYNC_STAGES        (SS)
    ) dut (
        .wclk_i         (wclk_i),
        .wreset_i       (wreset_i),
        .wr_en_i        (wr_en_i),
        .rd_ptr_i       (rd_ptr_i),
        .wr_ptr_o       (wr_ptr_o),
        .waddr_o        (waddr_o),
        .wfull_o        (wfull_o),
        .walmost_full_o (walmost_full_o),
        .wlevel_o       (wlevel_o),
        .woverflow_o    (woverflow_o),
        .wclr_ovf_i     (wclr_ovf_i)
    );

    always #5 wclk_i = ~wclk_i;

    // Model: absolute counts of accepted writes and read-side advances.
    int rd_cnt   = 0;
    int m_wcnt   = 0;
    int m_level  = 0;
    bit m_full   = 0;
    bit m_af     = 0;
    bit m_ovf    = 0;
    bit model_on = 0;
    int m_hist [SS];

    function automatic int gray(input int v);
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge wclk_i) begin
        int  seen;
        if (wreset_i) begin
            m_wcnt = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0;
            for (int i = 0; i < SS; i++) m_hist[i] = 0;
            model_on = 1;
        end else begin
            seen = m_hist[SS-1];
            if (wr_en_i && m_full) m_ovf = 1;
            else if (wclr_ovf_i) m_ovf = 0;
            if (wr_en_i && !m_full) m_wcnt++;
            m_level = m_wcnt - seen;
            m_full  = (m_level == DEPTH);
            m_af    = (m_level >= DEPTH - AFB);
            for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = rd_cnt;
        end
        #1;
        if (model_on) begin
            $display("cyc rst=%b wr=%b rd=%0d ptr=%b addr=%0d lvl=%0d full=%b af=%b ovf=%b",
                     wreset_i, wr_en_i, rd_cnt, wr_ptr_o, waddr_o, wlevel_o, wfull_o,
                     walmost_full_o, woverflow_o);
            check("m_ptr",   32'(wr_ptr_o),       32'(gray(m_wcnt % PTR_MOD)));
            check("m_addr",  32'(waddr_o),        32'(m_wcnt % DEPTH));
            check("m_level", 32'(wlevel_o),       32'(m_level));
            check("m_full",  32'(wfull_o),        32'(m_full));
            check("m_af",    32'(walmost_full_o), 32'(m_af));
            check("m_ovf",   32'(woverflow_o),    32'(m_ovf));
        end
    end

    task automatic tick();
        @(posedge wclk_i);
        @(negedge wclk_i);
    endtask

    task automatic set_rd(input int v);
        rd_cnt   = v;
        rd_ptr_i = PW'(gray(v % PTR_MOD));
    endtask

    task automatic do_reset();
        wreset_i   = 1'b1;
        wr_en_i    = 1'b0;
        wclr_ovf_i = 1'b0;
        set_rd(0);
        tick();
        wreset_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int fulls;
        set_rd(0);
        tick();
        tick();
        wreset_i = 1'b0;
        check("reset_ptr",  32'(wr_ptr_o), 32'd0);
        check("reset_full", 32'(wfull_o),  32'd0);

        // 16 back-to-back writes fill the FIFO
        wr_en_i = 1'b1;
        repeat (16) tick();
        wr_en_i = 1'b0;
        check("fill16_ptr",   32'(wr_ptr_o), 32'b11000);
        check("fill16_full",  32'(wfull_o),  32'd1);
        check("fill16_level", 32'(wlevel_o), 32'd16);

        // write while full: pointer holds, overflow sticks until cleared
        wr_en_i = 1'b1;
        tick();
        wr_en_i = 1'b0;
        check("ovf_ptr_hold", 32'(wr_ptr_o),    32'b11000);
        check("ovf_set",      32'(woverflow_o), 32'd1);
        repeat (3) tick();
        check("ovf_sticky",   32'(woverflow_o), 32'd1);
        wclr_ovf_i = 1'b1;
        wr_en_i    = 1'b1;
        tick();
        wr_en_i = 1'b0;
        check("ovf_set_wins", 32'(woverflow_o), 32'd1);
        tick();
        wclr_ovf_i = 1'b0;
        check("ovf_cleared",  32'(woverflow_o), 32'd0);

        // re-arm overflow, then one read step must take SS+1 cycles to drop full
        wr_en_i = 1'b1;
        tick();
        wr_en_i = 1'b0;
        set_rd(1);
        repeat (SS) begin
            tick();
            check("full_held_in_sync", 32'(wfull_o), 32'd1);
        end
        tick();
        check("full_fall",       32'(wfull_o),  32'd0);
        check("full_fall_level", 32'(wlevel_o), 32'd15);

        // reset clears sticky overflow; almost-full boundary at 13/14 entries
        do_reset();
        check("rst_ovf",  32'(woverflow_o), 32'd0);
        check("rst_ptr2", 32'(wr_ptr_o),    32'd0);
        wr_en_i = 1'b1;
        repeat (13) tick();
        wr_en_i = 1'b0;
        check("af13_af",    32'(walmost_full_o), 32'd0);
        check("af13_level", 32'(wlevel_o),       32'd13);
        wr_en_i = 1'b1;
        tick();
        wr_en_i = 1'b0;
        check("af14_af",   32'(walmost_full_o), 32'd1);
        check("af14_full", 32'(wfull_o),        32'd0);

        // mid-operation reset with write held high, then first write after release
        do_reset();
        wr_en_i = 1'b1;
        repeat (9) tick();
        check("pre_rst_level", 32'(wlevel_o), 32'd9);
        wreset_i = 1'b1;
        tick();
        check("midrst_ptr",   32'(wr_ptr_o),       32'd0);
        check("midrst_addr",  32'(waddr_o),        32'd0);
        check("midrst_level", 32'(wlevel_o),       32'd0);
        check("midrst_af",    32'(walmost_full_o), 32'd0);
        wreset_i = 1'b0;
        tick();
        wr_en_i = 1'b0;
        check("post_rst_ptr",  32'(wr_ptr_o), 32'b00001);
        check("post_rst_addr", 32'(waddr_o),  32'd1);

        // 40 writes with interleaved read steps across two pointer wraps
        do_reset();
        fulls   = 0;
        wr_en_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ((i % 4) != 0 && rd_cnt < m_wcnt) set_rd(rd_cnt + 1);
            tick();
            if (wfull_o) fulls++;
        end
        wr_en_i = 1'b0;
        repeat (20) begin
            if (rd_cnt < m_wcnt) set_rd(rd_cnt + 1);
            tick();
            if (wfull_o) fulls++;
        end
        check("wrap_no_full", 32'(fulls),    32'd0);
        check("wrap_ptr",     32'(wr_ptr_o), 32'b01100);
        check("wrap_addr",    32'(waddr_o),  32'd8);
        check("wrap_level",   32'(wlevel_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/async_fifo_wptr_full_ctrl.md
ASYNC_FIFO_WPTR_FULL_CTRL -- requirements
Module: async_fifo_wptr_full_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, meaning log2 of FIFO depth; DEPTH = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter ALMOST_FULL_BUFFER, default 2, meaning the free-slot count at or below which almost-full asserts.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning the flop count of the read-pointer synchronizer (minimum 2).
REQ-004 SHALL have ports wclk_i in 1, the write clock; all logic is in this single clock domain.
REQ-005 SHALL have port wreset_i in 1, a synchronous, active-high reset.
REQ-006 SHALL have port wr_en_i in 1, a write request.
REQ-007 SHALL have port rd_ptr_i in ADDR_WIDTH+1, the gray-coded read pointer, asynchronous to wclk_i.
REQ-008 SHALL have port wr_ptr_o out ADDR_WIDTH+1, the registered gray-coded write pointer.
REQ-009 SHALL have port waddr_o out ADDR_WIDTH, the registered binary memory write address.
REQ-010 SHALL have port wfull_o out 1, the registered full flag.
REQ-011 SHALL have port walmost_full_o out 1, the registered almost-full flag.
REQ-012 SHALL have port wlevel_o out ADDR_WIDTH+1, the registered fill level as seen from the write side.
REQ-013 SHALL have port woverflow_o out 1, a sticky flag for writes attempted while full.
REQ-014 SHALL have port wclr_ovf_i in 1, which clears woverflow_o.

Function
REQ-015 SHALL pass rd_ptr_i through SYNC_STAGES flops to form rsync_rd_ptr; latency is SYNC_STAGES wclk_i cycles.
REQ-016 SHALL compute do_write = wr_en_i & ~wfull_o, so that a write is accepted only when wfull_o is low in that cycle.
REQ-017 SHALL hold a binary write pointer wr_bin (ADDR_WIDTH+1 bits); next_bin = wr_bin + do_write, wrapping modulo 2**(ADDR_WIDTH+1).
REQ-018 SHALL compute next_gray = (next_bin>>1) ^ next_bin, and register wr_ptr_o <= next_gray and waddr_o <= next_bin[ADDR_WIDTH-1:0] every cycle.
REQ-019 SHALL register wfull_o <= (next_gray == {~rsync[AW:AW-1], rsync[AW-2:0]}), where rsync is rsync_rd_ptr; this means full asserts in the same cycle the DEPTH-th entry pointer becomes visible.
REQ-020 SHALL convert rsync_rd_ptr to binary rsync_bin each cycle and register wlevel_o <= next_bin - rsync_bin, modulo 2**(ADDR_WIDTH+1); the range is 0..DEPTH.
REQ-021 SHALL register walmost_full_o <= (next_bin - rsync_bin) >= DEPTH - ALMOST_FULL_BUFFER.
REQ-022 SHALL deassert wfull_o only after the read pointer advance has passed the synchronizer; the flags are pessimistic (never report fewer entries than are actually present).
REQ-023 SHALL set woverflow_o on wr_en_i & wfull_o; wclr_ovf_i clears it; if both occur in the same cycle, the set wins.
REQ-024 SHALL keep the pointer unchanged when wr_en_i is high while full; no write is accepted.
REQ-025 SHALL handle wrap-around of the pointer MSB with no special case; full and level remain correct across any number of wraps.

Reset
REQ-026 SHALL, on wreset_i high at a wclk_i edge, clear wr_bin, wr_ptr_o, waddr_o, wlevel_o, all synchronizer flops, wfull_o, walmost_full_o and woverflow_o to 0.
REQ-027 SHALL let reset override every other input in the same cycle, including a mid-operation reset; the first write is accepted in the cycle after wreset_i falls.

Structure
REQ-028 SHALL place the gray-to-binary and binary-to-gray functions in the shared package async_fifo_pkg, for use by both pointer controllers.
REQ-029 SHALL implement the synchronizer as the sub-module async_fifo_sync (parameters WIDTH, STAGES), reusable on the read side.

Verification
REQ-030 SHALL cover this case: after reset, with rd_ptr_i=0 and wr_en_i high for 16 cycles -> wr_ptr_o reaches gray(16)=5'b11000, wfull_o=1 after the 16th write, and wlevel_o=16.
REQ-031 SHALL cover this case: a FIFO that is full at 16 entries, then one extra write request -> the pointer is unchanged and woverflow_o=1; woverflow_o stays 1 until a wclr_ovf_i pulse, then 0.
REQ-032 SHALL cover this case: writing 14 entries with ALMOST_FULL_BUFFER=2 -> walmost_full_o=1 and wfull_o=0; at 13 entries, walmost_full_o=0.
REQ-033 SHALL cover this case: a full FIFO where rd_ptr_i steps gray(0)->gray(1) -> wfull_o falls exactly SYNC_STAGES+1 cycles later and wlevel_o=15.
REQ-034 SHALL cover this case: 40 writes interleaved with read-pointer steps across two MSB wraps -> wlevel_o always equals the model value, with no false wfull_o.
REQ-035 SHALL cover this case: wreset_i asserted at 9 entries -> the next cycle shows all outputs 0, and a write in the cycle after release gives wr_ptr_o=5'b00001.
